// File: rtl/alu_writeback.sv
// ALU result writeback stage: one 8-bit register-file write port, wide results split over two cycles.
// Optional feature macro: ALU_WB_DIVZERO_TRAP_EN (divide-by-zero trap with sticky flag_dz).
module alu_writeback #(
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_mode,
   input  logic [ADDR_W-1:0] in_dst,
   input  logic [7:0]        in_ao,
   input  logic [7:0]        in_bo,
   input  logic              in_cout,
   input  logic              in_bzero,
   input  logic              flag_clr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              flag_z,
   output logic              flag_c,
   output logic              flag_dz
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_HI_PEND = 1'b1} state_t;

   state_t              state_r, state_s;
   logic                wr_en_r, wr_en_s;
   logic [ADDR_W-1:0]   wr_addr_r, wr_addr_s;
   logic [7:0]          wr_data_r, wr_data_s;
   logic [ADDR_W-1:0]   hold_addr_r, hold_addr_s;
   logic [7:0]          hold_data_r, hold_data_s;
   logic                flag_z_r, flag_z_s;
   logic                flag_c_r, flag_c_s;
   logic                accept_s;
   logic                trap_s;

   assign in_ready = (state_r == ST_IDLE);
   assign accept_s = in_valid && (state_r == ST_IDLE);

`ifdef ALU_WB_DIVZERO_TRAP_EN
   logic flag_dz_r;
   logic dz_set_s;

   assign trap_s   = (in_mode == 3'b101) && in_bzero;
   assign dz_set_s = accept_s && trap_s;
   assign flag_dz  = flag_dz_r;

   // Sticky divide-by-zero flag; a set beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_dz_r <= 1'b0;
      end else if (dz_set_s) begin
         flag_dz_r <= 1'b1;
      end else if (flag_clr) begin
         flag_dz_r <= 1'b0;
      end else begin
         flag_dz_r <= flag_dz_r;
      end
   end
`else
   logic unused_ok_s;

   assign trap_s      = 1'b0;
   assign flag_dz     = 1'b0;
   assign unused_ok_s = ^{in_bzero, flag_clr};
`endif

   // Next-state, write-port and flag decode.
   always_comb begin
      state_s     = state_r;
      wr_en_s     = 1'b0;
      wr_addr_s   = wr_addr_r;
      wr_data_s   = wr_data_r;
      hold_addr_s = hold_addr_r;
      hold_data_s = hold_data_r;
      flag_z_s    = flag_z_r;
      flag_c_s    = flag_c_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               case (in_mode)
                  3'b111: begin
                     state_s = ST_IDLE;
                  end
                  3'b100, 3'b101: begin
                     if (trap_s) begin
                        state_s = ST_IDLE;
                     end else begin
                        wr_en_s     = 1'b1;
                        wr_addr_s   = in_dst;
                        wr_data_s   = in_ao;
                        // High byte lands in the next register, wrapping at the top.
                        hold_addr_s = in_dst + ADDR_W'(1'b1);
                        hold_data_s = in_bo;
                        flag_z_s    = ({in_bo, in_ao} == 16'h0000);
                        state_s     = ST_HI_PEND;
                     end
                  end
                  default: begin
                     wr_en_s   = 1'b1;
                     wr_addr_s = in_dst;
                     wr_data_s = in_ao;
                     flag_z_s  = (in_ao == 8'h00);
                     if (in_mode == 3'b000 || in_mode == 3'b001) begin
                        flag_c_s = in_cout;
                     end else begin
                        flag_c_s = flag_c_r;
                     end
                  end
               endcase
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_HI_PEND: begin
            wr_en_s   = 1'b1;
            wr_addr_s = hold_addr_r;
            wr_data_s = hold_data_r;
            state_s   = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, write port, hold buffer and Z/C flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         wr_en_r     <= 1'b0;
         wr_addr_r   <= '0;
         wr_data_r   <= 8'h00;
         hold_addr_r <= '0;
         hold_data_r <= 8'h00;
         flag_z_r    <= 1'b0;
         flag_c_r    <= 1'b0;
      end else begin
         state_r     <= state_s;
         wr_en_r     <= wr_en_s;
         wr_addr_r   <= wr_addr_s;
         wr_data_r   <= wr_data_s;
         hold_addr_r <= hold_addr_s;
         hold_data_r <= hold_data_s;
         flag_z_r    <= flag_z_s;
         flag_c_r    <= flag_c_s;
      end
   end

   assign wr_en   = wr_en_r;
   assign wr_addr = wr_addr_r;
   assign wr_data = wr_data_r;
   assign flag_z  = flag_z_r;
   assign flag_c  = flag_c_r;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed, table-driven bench for alu_writeback (ADDR_W=3), plus multi-cycle corner sequences.
module tb_alu_writeback;

   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_mode;
   logic [ADDR_W-1:0] in_dst;
   logic [7:0]        in_ao;
   logic [7:0]        in_bo;
   logic              in_cout;
   logic              in_bzero;
   logic              flag_clr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              flag_z;
   logic              flag_c;
   logic              flag_dz;

   int total = 0;
   int bad   = 0;

   alu_writeback #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_dst(in_dst), .in_ao(in_ao), .in_bo(in_bo),
      .in_cout(in_cout), .in_bzero(in_bzero), .flag_clr(flag_clr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .flag_z(flag_z), .flag_c(flag_c), .flag_dz(flag_dz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]        mode;
      logic [ADDR_W-1:0] dst;
      logic [7:0]        ao;
      logic [7:0]        bo;
      logic              cout;
      logic              en;      // low-byte write expected
      logic              hi;      // high-byte write expected next cycle
      logic [ADDR_W-1:0] hi_addr;
      logic              z;
      logic              c;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] m, input logic [ADDR_W-1:0] d, input logic [7:0] a,
                        input logic [7:0] b, input logic co, input logic bz);
      in_mode  = m;
      in_dst   = d;
      in_ao    = a;
      in_bo    = b;
      in_cout  = co;
      in_bzero = bz;
      in_valid = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      drive(v.mode, v.dst, v.ao, v.bo, v.cout, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d wr_en", idx), 32'(wr_en), 32'(v.en));
      if (v.en) begin
         chk($sformatf("v%0d wr_addr", idx), 32'(wr_addr), 32'(v.dst));
         chk($sformatf("v%0d wr_data", idx), 32'(wr_data), 32'(v.ao));
      end
      chk($sformatf("v%0d flag_z", idx), 32'(flag_z), 32'(v.z));
      chk($sformatf("v%0d flag_c", idx), 32'(flag_c), 32'(v.c));
      chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(!v.hi));
      if (v.hi) begin
         @(negedge clk);
         chk($sformatf("v%0d hi wr_en", idx), 32'(wr_en), 32'd1);
         chk($sformatf("v%0d hi wr_addr", idx), 32'(wr_addr), 32'(v.hi_addr));
         chk($sformatf("v%0d hi wr_data", idx), 32'(wr_data), 32'(v.bo));
         chk($sformatf("v%0d hi in_ready", idx), 32'(in_ready), 32'd1);
      end
      @(negedge clk);
      chk($sformatf("v%0d idle wr_en", idx), 32'(wr_en), 32'd0);
   endtask

   initial begin
      //          mode    dst   ao     bo     cout  en    hi    hi_a  z     c
      vecs[0]  = '{3'b001, 3'd1, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
      vecs[1]  = '{3'b000, 3'd4, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
      vecs[2]  = '{3'b010, 3'd5, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[3]  = '{3'b110, 3'd6, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
      vecs[4]  = '{3'b100, 3'd7, 8'h34, 8'h12, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
      vecs[5]  = '{3'b100, 3'd3, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0};
      vecs[6]  = '{3'b101, 3'd2, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0};
      vecs[7]  = '{3'b111, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[8]  = '{3'b000, 3'd0, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
      vecs[9]  = '{3'b111, 3'd2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
      vecs[10] = '{3'b011, 3'd3, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      flag_clr = 1'b0;
      drive(3'b000, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
      in_valid = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst wr_en", 32'(wr_en), 32'd0);
      chk("rst wr_addr", 32'(wr_addr), 32'd0);
      chk("rst wr_data", 32'(wr_data), 32'd0);
      chk("rst flags", 32'({flag_z, flag_c, flag_dz}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // Narrow back-to-back
      @(negedge clk);
      drive(3'b000, 3'd2, 8'h00, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      chk("b2b w1 en", 32'(wr_en), 32'd1);
      chk("b2b w1 addr/data", 32'({wr_addr, wr_data}), 32'({3'd2, 8'h00}));
      chk("b2b w1 z/c", 32'({flag_z, flag_c}), 32'b11);
      drive(3'b011, 3'd3, 8'h5A, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b w2 en", 32'(wr_en), 32'd1);
      chk("b2b w2 addr/data", 32'({wr_addr, wr_data}), 32'({3'd3, 8'h5A}));
      chk("b2b w2 z/c", 32'({flag_z, flag_c}), 32'b01);
      @(negedge clk);
      chk("b2b idle", 32'(wr_en), 32'd0);

      // Backpressure: wide op then narrow op with in_valid held high
      drive(3'b100, 3'd5, 8'hAA, 8'hBB, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp lo", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 3'd5, 8'hAA}));
      chk("bp ready lo", 32'(in_ready), 32'd0);
      drive(3'b010, 3'd1, 8'h11, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp hi", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 3'd6, 8'hBB}));
      chk("bp ready hi", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp narrow", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 3'd1, 8'h11}));
      chk("bp z/c", 32'({flag_z, flag_c}), 32'b01);
      @(negedge clk);
      chk("bp no dup", 32'(wr_en), 32'd0);

      // Divide by zero (flags entering: Z=0, C=1)
      drive(3'b101, 3'd2, 8'h00, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
`ifdef ALU_WB_DIVZERO_TRAP_EN
      chk("dz no write", 32'(wr_en), 32'd0);
      chk("dz flags", 32'({flag_z, flag_c, flag_dz}), 32'b011);
      chk("dz ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("dz no hi", 32'(wr_en), 32'd0);
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
      chk("dz clr", 32'(flag_dz), 32'd0);
      drive(3'b101, 3'd2, 8'h00, 8'h00, 1'b0, 1'b1);
      flag_clr = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      flag_clr = 1'b0;
      chk("dz set wins", 32'(flag_dz), 32'd1);
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
      chk("dz clr2", 32'(flag_dz), 32'd0);
`else
      chk("dz lo", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 3'd2, 8'h00}));
      chk("dz flags", 32'({flag_z, flag_c, flag_dz}), 32'b110);
      @(negedge clk);
      chk("dz hi", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 3'd3, 8'h00}));
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
      chk("dz stays 0", 32'(flag_dz), 32'd0);
`endif

      // Reset while HI_PEND
      @(negedge clk);
      drive(3'b100, 3'd7, 8'h01, 8'h02, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("rh pending", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("rh outputs", 32'({wr_en, wr_addr, wr_data, flag_z, flag_c, flag_dz}), 32'd0);
      chk("rh ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rh no hi 1", 32'(wr_en), 32'd0);
      @(negedge clk);
      chk("rh no hi 2", 32'(wr_en), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
